// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot frame sequencer.
package mandelbrot_pkg;

    localparam int W         = 32;
    localparam int CW        = 15;
    localparam int DIV_STEPS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV_X,
        S_DIV_Y,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } frame_state_t;

    function automatic logic [19:0] pack_addr(input logic [9:0] y, input logic [9:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/seq_divider.sv
// 32/10 unsigned restoring divider: load cycle plus 32 shift/subtract steps.
// done marks the final step; quotient is valid from the following cycle until the next ld.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [31:0] dividend,
    input  logic [9:0]  divisor,
    output logic [31:0] quotient,
    output logic        done
);
    import mandelbrot_pkg::*;

    logic [9:0]  rem_q;
    logic [9:0]  dvs_q;
    logic [5:0]  cnt_q;
    logic [10:0] trial;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial = {rem_q, quotient[31]};
    assign done  = (cnt_q == 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            quotient <= '0;
        end else if (ld) begin
            rem_q    <= '0;
            dvs_q    <= divisor;
            cnt_q    <= 6'(DIV_STEPS);
            quotient <= dividend;
        end else if (cnt_q != 6'd0) begin
            // The remainder always stays below the divisor, so 10 bits hold it.
            if (trial >= {1'b0, dvs_q}) begin
                rem_q    <= trial[9:0] - dvs_q;
                quotient <= {quotient[30:0], 1'b1};
            end else begin
                rem_q    <= trial[9:0];
                quotient <= {quotient[30:0], 1'b0};
            end
            cnt_q <= cnt_q - 6'd1;
        end
    end

endmodule

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame sequencer: computes pixel steps, walks pixels in raster order through the
// iteration engine and writes each saturated count into the frame buffer at {y,x}.
module mandelbrot_frame_ctrl #(
    parameter int W  = mandelbrot_pkg::W,
    parameter int CW = mandelbrot_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [9:0]    x_size,
    input  logic [9:0]    y_size,
    input  logic [W-1:0]  re_origin,
    input  logic [W-1:0]  im_origin,
    input  logic [W-1:0]  re_axis_width,
    input  logic [W-1:0]  im_axis_width,
    input  logic [CW-1:0] max_iter,
    output logic          busy,
    output logic          frame_done,
    output logic          eng_start,
    output logic [W-1:0]  eng_c_re,
    output logic [W-1:0]  eng_c_im,
    output logic [CW-1:0] eng_max_iter,
    input  logic          eng_done,
    input  logic [CW-1:0] eng_count,
    output logic          fb_we,
    output logic [19:0]   fb_addr,
    output logic [CW-1:0] fb_data
);
    import mandelbrot_pkg::*;

    frame_state_t state_q, state_d;

    logic [9:0]    x_size_q, y_size_q, x_q, y_q;
    logic [W-1:0]  re_o_q, im_o_q, re_w_q, im_w_q;
    logic [W-1:0]  delta_x_q, c_re_q, c_im_q;
    logic [CW-1:0] max_iter_q, count_q, count_sat;
    logic          div_ld_q, div_ld_d, div_done;
    logic [31:0]   div_dividend, div_quot;
    logic [9:0]    div_divisor;
    logic          last_x, last_y;

    assign last_x    = (x_q == x_size_q - 10'd1);
    assign last_y    = (y_q == y_size_q - 10'd1);
    assign count_sat = (eng_count > max_iter_q) ? max_iter_q : eng_count;

    // One divider serves both axes; the operands follow the current divide state.
    assign div_dividend = (state_q == S_DIV_Y) ? im_w_q : re_w_q;
    assign div_divisor  = (state_q == S_DIV_Y) ? y_size_q : x_size_q;

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .ld       (div_ld_q),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_ld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_ld_q <= div_ld_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        div_ld_d = 1'b0;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (x_size == 10'd0 || y_size == 10'd0) ? S_DONE : S_DIV_X;
            S_DIV_X: if (div_done) state_d = S_DIV_Y;
            S_DIV_Y: if (div_done) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (eng_done) state_d = S_WRITE;
            S_WRITE: state_d = (last_x && last_y) ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Load the divider on the first cycle of each divide state.
        div_ld_d = (state_d == S_DIV_X || state_d == S_DIV_Y) && (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_size_q   <= '0;
            y_size_q   <= '0;
            re_o_q     <= '0;
            im_o_q     <= '0;
            re_w_q     <= '0;
            im_w_q     <= '0;
            max_iter_q <= '0;
            delta_x_q  <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    x_size_q   <= x_size;
                    y_size_q   <= y_size;
                    re_o_q     <= re_origin;
                    im_o_q     <= im_origin;
                    re_w_q     <= re_axis_width;
                    im_w_q     <= im_axis_width;
                    max_iter_q <= max_iter;
                end
                S_DIV_Y: begin
                    // The X quotient is still held on the cycle the Y divide loads.
                    if (div_ld_q) delta_x_q <= div_quot;
                    if (div_done) begin
                        x_q    <= '0;
                        y_q    <= '0;
                        c_re_q <= re_o_q;
                        c_im_q <= im_o_q;
                    end
                end
                S_WAIT: if (eng_done) count_q <= count_sat;
                S_WRITE: begin
                    // delta_y is read straight from the divider, which holds it until the next frame.
                    if (!last_x) begin
                        x_q    <= x_q + 10'd1;
                        c_re_q <= c_re_q + delta_x_q;
                    end else if (!last_y) begin
                        x_q    <= '0;
                        y_q    <= y_q + 10'd1;
                        c_re_q <= re_o_q;
                        c_im_q <= c_im_q - div_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while rst is high so nothing leaks out of the reset cycle.
    assign busy         = !rst && (state_q != S_IDLE);
    assign frame_done   = !rst && (state_q == S_DONE);
    assign eng_start    = !rst && (state_q == S_ISSUE);
    assign fb_we        = !rst && (state_q == S_WRITE);
    assign eng_c_re     = rst ? '0 : c_re_q;
    assign eng_c_im     = rst ? '0 : c_im_q;
    assign eng_max_iter = rst ? '0 : max_iter_q;
    assign fb_addr      = rst ? '0 : pack_addr(y_q, x_q);
    assign fb_data      = rst ? '0 : count_q;

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
// Self-checking bench for mandelbrot_frame_ctrl with a behavioural engine and a write scoreboard.
module tb_mandelbrot_frame_ctrl;

    localparam int M_FIXED   = 0;
    localparam int M_RAND    = 1;
    localparam int M_SAT     = 2;
    localparam int M_DISTURB = 3;

    typedef struct packed {
        logic [19:0] addr;
        logic [14:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x_size = '0, y_size = '0;
    logic [31:0] re_origin = '0, im_origin = '0, re_axis_width = '0, im_axis_width = '0;
    logic [14:0] max_iter = '0;
    logic        busy, frame_done, eng_start, fb_we;
    logic [31:0] eng_c_re, eng_c_im;
    logic [14:0] eng_max_iter, fb_data;
    logic        eng_done = 1'b0;
    logic [14:0] eng_count = '0;
    logic [19:0] fb_addr;

    int n_assert = 0;
    int n_fail   = 0;
    wr_t sb[$];

    always #5 clk = ~clk;

    mandelbrot_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .x_size        (x_size),
        .y_size        (y_size),
        .re_origin     (re_origin),
        .im_origin     (im_origin),
        .re_axis_width (re_axis_width),
        .im_axis_width (im_axis_width),
        .max_iter      (max_iter),
        .busy          (busy),
        .frame_done    (frame_done),
        .eng_start     (eng_start),
        .eng_c_re      (eng_c_re),
        .eng_c_im      (eng_c_im),
        .eng_max_iter  (eng_max_iter),
        .eng_done      (eng_done),
        .eng_count     (eng_count),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data)
    );

    function automatic logic [117:0] all_outs();
        return {busy, frame_done, eng_start, fb_we, eng_c_re, eng_c_im, eng_max_iter, fb_addr, fb_data};
    endfunction

    // Renders one frame while acting as the engine; the cycle with start high is cycle 0.
    task automatic run_frame(input logic [9:0] xs, input logic [9:0] ys,
                             input logic [31:0] ro, input logic [31:0] rw,
                             input logic [31:0] io, input logic [31:0] iw,
                             input logic [14:0] mi, input int mode,
                             output int n_writes, output int done_cyc, output int first_issue);
        logic [31:0] dx, dy, exp_re, exp_im;
        logic [14:0] cnt, pend_cnt;
        wr_t         got, exp_w;
        int          issued, done_at, px, py;
        dx = rw / {22'd0, xs};
        dy = iw / {22'd0, ys};
        issued = 0; done_at = -1; pend_cnt = '0;
        n_writes = 0; done_cyc = -1; first_issue = -1;
        sb.delete();
        @(negedge clk);
        x_size = xs; y_size = ys; re_origin = ro; re_axis_width = rw;
        im_origin = io; im_axis_width = iw; max_iter = mi; start = 1'b1;
        for (int cyc = 1; cyc < 5000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0; eng_done = 1'b0; x_size = xs;
            if (mode == M_DISTURB && cyc == 80) begin
                start = 1'b1; x_size = 10'd7;
            end
            if (eng_start) begin
                px = issued % int'(xs);
                py = issued / int'(xs);
                exp_re = ro + 32'(px) * dx;
                exp_im = io - 32'(py) * dy;
                n_assert++;
                if ({eng_c_re, eng_c_im, eng_max_iter} !== {exp_re, exp_im, mi}) begin
                    n_fail++;
                    $display("FAIL coord px%0d: got re=%h im=%h mi=%0d, want re=%h im=%h mi=%0d",
                             issued, eng_c_re, eng_c_im, eng_max_iter, exp_re, exp_im, mi);
                end
                if (first_issue < 0) first_issue = cyc;
                cnt = (mode == M_SAT) ? 15'h7FFF : 15'(issued * 37 + 5);
                exp_w.addr = 20'((py << 10) | px);
                exp_w.data = (cnt > mi) ? mi : cnt;
                sb.push_back(exp_w);
                pend_cnt = cnt;
                done_at = cyc + ((mode == M_RAND) ? int'($urandom_range(1, 50)) : 1);
                issued++;
                if (mode == M_DISTURB) begin
                    eng_done = 1'b1; eng_count = 15'h1234;
                end
            end
            if (cyc == done_at) begin
                eng_done = 1'b1; eng_count = pend_cnt;
            end
            if (fb_we) begin
                got.addr = fb_addr; got.data = fb_data;
                n_assert++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got addr=%h data=%0d, want no write", fb_addr, fb_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (got !== exp_w) begin
                        n_fail++;
                        $display("FAIL write_%0d: got addr=%h data=%0d, want addr=%h data=%0d",
                                 n_writes, got.addr, got.data, exp_w.addr, exp_w.data);
                    end
                end
                n_writes++;
            end
            if (frame_done) done_cyc = cyc;
        end
        eng_done = 1'b0;
        n_assert++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done, want frame_done within budget");
        end
        n_assert++;
        if (n_writes != int'(xs) * int'(ys) || issued != n_writes || sb.size() != 0) begin
            n_fail++;
            $display("FAIL write_count: got writes=%0d issues=%0d pending=%0d, want %0d each, 0 pending",
                     n_writes, issued, sb.size(), int'(xs) * int'(ys));
        end
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done: got %b, want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL post_reset_outputs: got %h, want 0", all_outs());
        end
    endtask

    task automatic test_baseline();
        int nw, dc, fi;
        run_frame(10'd4, 10'd2, 32'hE0000000, 32'h40000000, 32'h10000000, 32'h20000000,
                  15'd200, M_FIXED, nw, dc, fi);
        n_assert++;
        if (fi != 67) begin
            n_fail++;
            $display("FAIL first_issue_cycle: got %0d, want 67", fi);
        end
        n_assert++;
        if (dc != 91) begin
            n_fail++;
            $display("FAIL frame_done_cycle: got %0d, want 91", dc);
        end
    endtask

    task automatic test_saturation();
        int nw, dc, fi;
        run_frame(10'd2, 10'd1, 32'h00000000, 32'h20000000, 32'h00000000, 32'h10000000,
                  15'd100, M_SAT, nw, dc, fi);
        n_assert++;
        if (dc != 67 + 2 * 3) begin
            n_fail++;
            $display("FAIL sat_done_cycle: got %0d, want %0d", dc, 67 + 6);
        end
    endtask

    task automatic test_zero_size();
        int dc, n_we, n_es;
        dc = -1; n_we = 0; n_es = 0;
        @(negedge clk);
        x_size = 10'd0; y_size = 10'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (frame_done && dc < 0) dc = cyc;
            if (fb_we) n_we++;
            if (eng_start) n_es++;
            if (cyc == 2) begin
                n_assert++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_busy_cycle2: got %b, want 0", busy);
                end
            end
        end
        n_assert++;
        if (dc != 1 || n_we != 0 || n_es != 0) begin
            n_fail++;
            $display("FAIL zero_size: got done_cycle=%0d we=%0d eng_start=%0d, want 1 0 0", dc, n_we, n_es);
        end
    endtask

    task automatic test_ignored_inputs();
        int nw, dc, fi;
        run_frame(10'd4, 10'd2, 32'hE0000000, 32'h40000000, 32'h10000000, 32'h20000000,
                  15'd200, M_DISTURB, nw, dc, fi);
        n_assert++;
        if (dc != 91 || fi != 67) begin
            n_fail++;
            $display("FAIL disturb_timing: got done=%0d issue=%0d, want 91 67", dc, fi);
        end
    endtask

    task automatic test_reset_in_wait();
        int nw, dc, fi;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        x_size = 10'd4; y_size = 10'd2; re_origin = 32'hE0000000; re_axis_width = 32'h40000000;
        im_origin = 32'h10000000; im_axis_width = 32'h20000000; max_iter = 15'd200; start = 1'b1;
        for (int cyc = 1; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (eng_start) seen = 1'b1;
        end
        n_assert++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_wait_issue: got no eng_start, want one by cycle 67");
        end
        @(negedge clk);
        rst = 1'b1; eng_done = 1'b1; eng_count = 15'd9;
        #1;
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL rst_in_wait_outputs: got %h, want 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0; eng_done = 1'b0;
        n_assert++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL rst_in_wait_after: got %h, want 0", all_outs());
        end
        run_frame(10'd4, 10'd2, 32'hE0000000, 32'h40000000, 32'h10000000, 32'h20000000,
                  15'd200, M_FIXED, nw, dc, fi);
        n_assert++;
        if (dc != 91) begin
            n_fail++;
            $display("FAIL rst_rerender_done: got %0d, want 91", dc);
        end
    endtask

    task automatic test_random_delay();
        int nw, dc, fi;
        run_frame(10'd3, 10'd3, 32'hF8000000, 32'h30000000, 32'h0C000000, 32'h18000000,
                  15'd300, M_RAND, nw, dc, fi);
        run_frame(10'd5, 10'd1, 32'h7FFFFFF0, 32'h00000050, 32'h00000000, 32'h00000007,
                  15'd50, M_RAND, nw, dc, fi);
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_saturation();
        test_zero_size();
        test_ignored_inputs();
        test_reset_in_wait();
        test_random_delay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
